// File: rtl/sap_alu_seq.sv
// Registered SAP-style ALU: single-cycle add/sub/logic with carry chaining, plus an
// iterative shift-add multiply, all under a START/BUSY/DONE handshake.
module sap_alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             START,
    input  logic             EU,
    output wire  [WIDTH-1:0] ALU_OUT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             BUSY,
    output logic             DONE,
    output logic [3:0]       FLAGS
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [0:0]         state_q,  state_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [3:0]         flags_q,  flags_d;
    logic               done_q,   done_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;

    logic [WIDTH-1:0]   b_term;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic               ovf;
    logic [WIDTH-1:0]   logic_r;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               last_iter;

    // OP[0] selects the inverted B term (SUB/SBB); OP[1] chains the stored carry (ADC/SBB).
    always_comb begin
        b_term = OP[0] ? ~B : B;
        cin    = OP[1] ? flags_q[3] : OP[0];
        sum    = {1'b0, A} + {1'b0, b_term} + {{WIDTH{1'b0}}, cin};
        ovf    = (A[WIDTH-1] == b_term[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        case (OP)
            OP_AND:  logic_r = A & B;
            OP_OR:   logic_r = A | B;
            default: logic_r = A ^ B;
        endcase
    end

    always_comb begin
        prod_nxt  = prod_q + (mplier_q[0] ? mcand_q : '0);
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (OP == OP_MUL) begin
                        if (MUL_EN) begin
                            mcand_d  = {{WIDTH{1'b0}}, A};
                            mplier_d = B;
                            prod_d   = '0;
                            cnt_d    = '0;
                            state_d  = ST_MUL;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else if (OP[2]) begin
                        res_lo_d = logic_r;
                        res_hi_d = '0;
                        flags_d  = {1'b0, (logic_r == '0), logic_r[WIDTH-1], 1'b0};
                        done_d   = 1'b1;
                    end else begin
                        res_lo_d = sum[WIDTH-1:0];
                        res_hi_d = '0;
                        flags_d  = {sum[WIDTH], (sum[WIDTH-1:0] == '0), sum[WIDTH-1], ovf};
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // One multiplier bit per edge; the visible result only changes on the last one.
                prod_d   = prod_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    res_lo_d = prod_nxt[WIDTH-1:0];
                    res_hi_d = prod_nxt[2*WIDTH-1:WIDTH];
                    flags_d  = {(|prod_nxt[2*WIDTH-1:WIDTH]), (prod_nxt == '0), 2'b00};
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!CLR_n) begin
            state_q  <= ST_IDLE;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign ALU_OUT   = EU ? res_lo_q : {WIDTH{1'bz}};
    assign RESULT_HI = res_hi_q;
    assign FLAGS     = flags_q;
    assign DONE      = done_q;
    assign BUSY      = (state_q == ST_MUL);

endmodule

// File: tb/tb_sap_alu_seq.sv
// Scoreboard bench for sap_alu_seq: 8-bit main instance plus 4-bit and no-multiply instances.
module tb_sap_alu_seq;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       CLR_n;
    logic [7:0] A, B;
    logic [2:0] OP;
    logic       START, EU;
    wire  [7:0] ALU_OUT;
    logic [7:0] RESULT_HI;
    logic       BUSY, DONE;
    logic [3:0] FLAGS;

    logic [3:0] A4, B4;
    logic [2:0] OP4;
    logic       START4;
    wire  [3:0] ALU4;
    logic [3:0] HI4;
    logic       BUSY4, DONE4;
    logic [3:0] FL4;

    logic [7:0] A0, B0;
    logic [2:0] OP0;
    logic       START0;
    wire  [7:0] ALU0;
    logic [7:0] HI0;
    logic       BUSY0, DONE0;
    logic [3:0] FL0;

    sap_alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .A(A), .B(B), .OP(OP), .START(START), .EU(EU),
        .ALU_OUT(ALU_OUT), .RESULT_HI(RESULT_HI), .BUSY(BUSY), .DONE(DONE), .FLAGS(FLAGS));

    sap_alu_seq #(.WIDTH(4), .MUL_EN(1'b1)) dut4 (
        .CLK(CLK), .CLR_n(CLR_n), .A(A4), .B(B4), .OP(OP4), .START(START4), .EU(1'b1),
        .ALU_OUT(ALU4), .RESULT_HI(HI4), .BUSY(BUSY4), .DONE(DONE4), .FLAGS(FL4));

    sap_alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
        .CLK(CLK), .CLR_n(CLR_n), .A(A0), .B(B0), .OP(OP0), .START(START0), .EU(1'b1),
        .ALU_OUT(ALU0), .RESULT_HI(HI0), .BUSY(BUSY0), .DONE(DONE0), .FLAGS(FL0));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] fl;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mflags;
    logic [7:0] prev_lo, prev_hi;

    // Reference model built from integer arithmetic, {C,Z,N,V}.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic c);
        exp_t e;
        int sa, sbv, u, r;
        logic [15:0] p;
        sa  = int'(a);  if (a[7]) sa  -= 256;
        sbv = int'(b);  if (b[7]) sbv -= 256;
        e.hi = 8'h00;
        u = 0; r = 0;
        case (op)
            3'd0: begin u = int'(a) + int'(b);             r = sa + sbv;                end
            3'd1: begin u = int'(a) + (255 - int'(b)) + 1; r = sa - sbv;                end
            3'd2: begin u = int'(a) + int'(b) + int'(c);   r = sa + sbv + int'(c);      end
            3'd3: begin u = int'(a) + (255 - int'(b)) + int'(c); r = sa - sbv - 1 + int'(c); end
            default: ;
        endcase
        if (op < 3'd4) begin
            e.lo = u[7:0];
            e.fl = {(u > 255), (e.lo == 8'h00), e.lo[7], (r > 127 || r < -128)};
        end else if (op == 3'd7) begin
            p    = 16'(a) * 16'(b);
            e.lo = p[7:0];
            e.hi = p[15:8];
            e.fl = {(p[15:8] != 8'h00), (p == 16'h0000), 2'b00};
        end else begin
            e.lo = (op == 3'd4) ? (a & b) : (op == 3'd5) ? (a | b) : (a ^ b);
            e.fl = {1'b0, (e.lo == 8'h00), e.lo[7], 1'b0};
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (DONE) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(DONE), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (EU) chk({e.tag, "_lo"}, 32'(ALU_OUT), 32'(e.lo));
                chk({e.tag, "_hi"}, 32'(RESULT_HI), 32'(e.hi));
                chk({e.tag, "_flags"}, 32'(FLAGS), 32'(e.fl));
            end
        end
    end

    // Called at a negedge; returns at the negedge where DONE is seen.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input bit disturb);
        exp_t e;
        int n, bcnt;
        e = model(op, a, b, mflags[3]);
        e.tag = tag;
        mflags = e.fl;
        sb.push_back(e);
        A = a; B = b; OP = op; START = 1'b1;
        n = 0; bcnt = 0;
        do begin
            @(negedge CLK);
            n++;
            START = disturb && (n == 3);
            if (disturb && n == 3) begin
                A = 8'h12; B = 8'h34; OP = 3'b000;
            end
            if (BUSY) bcnt++;
            if (op == 3'd7 && n == 2) begin
                chk({tag, "_hold_lo"}, 32'(ALU_OUT), 32'(prev_lo));
                chk({tag, "_hold_hi"}, 32'(RESULT_HI), 32'(prev_hi));
            end
        end while (!DONE && n < 30);
        chk({tag, "_lat"}, n, (op == 3'd7) ? 9 : 1);
        chk({tag, "_busy"}, bcnt, (op == 3'd7) ? 8 : 0);
        prev_lo = e.lo;
        prev_hi = e.hi;
    endtask

    task automatic run4(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] elo, input logic [3:0] ehi, input logic [3:0] efl, input int elat);
        int n;
        A4 = a; B4 = b; OP4 = op; START4 = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            START4 = 1'b0;
        end while (!DONE4 && n < 30);
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_lo"}, 32'(ALU4), 32'(elo));
        chk({tag, "_hi"}, 32'(HI4), 32'(ehi));
        chk({tag, "_flags"}, 32'(FL4), 32'(efl));
    endtask

    task automatic run0(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] elo, input logic [3:0] efl);
        int n;
        A0 = a; B0 = b; OP0 = op; START0 = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            START0 = 1'b0;
        end while (!DONE0 && n < 30);
        chk({tag, "_lat"}, n, 1);
        chk({tag, "_lo"}, 32'(ALU0), 32'(elo));
        chk({tag, "_hi"}, 32'(HI0), 32'd0);
        chk({tag, "_flags"}, 32'(FL0), 32'(efl));
        chk({tag, "_busy"}, 32'(BUSY0), 32'd0);
        @(negedge CLK);
        chk({tag, "_pulse"}, 32'(DONE0), 32'd0);
    endtask

    initial begin
        CLR_n = 1'b0; START = 1'b0; EU = 1'b1; A = '0; B = '0; OP = '0;
        A4 = '0; B4 = '0; OP4 = '0; START4 = 1'b0;
        A0 = '0; B0 = '0; OP0 = '0; START0 = 1'b0;
        mflags = 4'h0; prev_lo = 8'h00; prev_hi = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_lo", 32'(ALU_OUT), 32'd0);
        chk("rst_hi", 32'(RESULT_HI), 32'd0);
        chk("rst_flags", 32'(FLAGS), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        CLR_n = 1'b1;
        @(negedge CLK);

        do_op("add_35_34", 3'd0, 8'h35, 8'h34, 1'b0);
        do_op("sub_35_34", 3'd1, 8'h35, 8'h34, 1'b0);
        do_op("sub_34_35", 3'd1, 8'h34, 8'h35, 1'b0);
        do_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 1'b0);
        do_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 1'b0);
        do_op("adc_00_00", 3'd2, 8'h00, 8'h00, 1'b0);
        do_op("sbb_50_20", 3'd3, 8'h50, 8'h20, 1'b0);
        do_op("sbb_80_01", 3'd3, 8'h80, 8'h01, 1'b0);
        do_op("and", 3'd4, 8'hF0, 8'h3C, 1'b0);
        do_op("or", 3'd5, 8'h81, 8'h02, 1'b0);
        do_op("xor_z", 3'd6, 8'hA5, 8'hA5, 1'b0);
        do_op("mul_0", 3'd7, 8'h00, 8'h9C, 1'b0);
        do_op("mul_small", 3'd7, 8'h0B, 8'h0D, 1'b0);
        do_op("mul_ff_ff", 3'd7, 8'hFF, 8'hFF, 1'b1);
        do_op("add_in_done", 3'd0, 8'h01, 8'h02, 1'b0);
        do_op("mul_again", 3'd7, 8'hFF, 8'hFF, 1'b0);

        // Abort a multiply with reset after three iterations.
        A = 8'hFF; B = 8'hFF; OP = 3'd7; START = 1'b1;
        @(negedge CLK); START = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort_busy_before", 32'(BUSY), 32'd1);
        CLR_n = 1'b0;
        @(negedge CLK);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_lo", 32'(ALU_OUT), 32'd0);
        chk("abort_hi", 32'(RESULT_HI), 32'd0);
        chk("abort_flags", 32'(FLAGS), 32'd0);
        CLR_n = 1'b1;
        mflags = 4'h0; prev_lo = 8'h00; prev_hi = 8'h00;
        repeat (12) @(negedge CLK);
        chk("abort_idle_busy", 32'(BUSY), 32'd0);

        @(posedge CLK); #1 EU = 1'b0;
        @(negedge CLK);
        do_op("eu_off", 3'd0, 8'h10, 8'h22, 1'b0);
        @(posedge CLK); #1 EU = 1'b1;
        #1 chk("eu_back", 32'(ALU_OUT), 32'h32);
        @(negedge CLK);

        for (int i = 0; i < 16; i++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(0, 7));
            do_op($sformatf("rnd%0d", i), rop, 8'($urandom), 8'($urandom), 1'b0);
        end

        run4("w4_add", 3'd0, 4'h9, 4'h8, 4'h1, 4'h0, 4'h9, 1);
        run4("w4_mul", 3'd7, 4'hF, 4'hF, 4'h1, 4'hE, 4'h8, 5);

        run0("nm_add", 3'd0, 8'hFF, 8'h01, 8'h00, 4'hC);
        run0("nm_mul", 3'd7, 8'hFF, 8'hFF, 8'h00, 4'hC);

        repeat (3) @(negedge CLK);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
